// File: rtl/xnor_cmp_scheduler_if.sv
// Bundle of signals between xnor_cmp_scheduler and its parent: client request and operand
// buses, completion results, and the link to the shared 1-bit XNOR cell.
interface xnor_cmp_scheduler_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             xa;
    logic             xb;
    logic             xc;
    logic [1:0]       ack;
    logic             eq;
    logic [CW-1:0]    mism;
    logic             busy;
    logic             gnt_id;

    // Parent side: clients plus the XNOR cell.
    modport master (
        output req, a0, b0, a1, b1, xc,
        input  xa, xb, ack, eq, mism, busy, gnt_id
    );

    // Scheduler side.
    modport slave (
        input  req, a0, b0, a1, b1, xc,
        output xa, xb, ack, eq, mism, busy, gnt_id
    );
endinterface

// File: rtl/xnor_cmp_scheduler.sv
// Round-robin scheduler that shares one external XNOR cell between two requesters,
// serialising operand pairs LSB first and returning an equality flag and mismatch count.
module xnor_cmp_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xnor_cmp_scheduler_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eq_acc_q, eq_acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [1:0]       ack_q, ack_d;
    logic             eq_q, eq_d;
    logic [CW-1:0]    mism_q, mism_d;

    logic             grant_s;
    logic             miss_s;
    logic             eq_next_s;
    logic [CW-1:0]    cnt_next_s;

    // Round-robin pick: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req == 2'b11) begin
            grant_s = ~last_q;
        end else begin
            grant_s = bus.req[1];
        end
    end

    // Accumulator update for the bit pair currently on the cell.
    always_comb begin
        miss_s     = ~bus.xc;
        eq_next_s  = eq_acc_q & bus.xc;
        cnt_next_s = cnt_q + CW'(miss_s);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        idx_d    = idx_q;
        eq_acc_d = eq_acc_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        ack_d    = 2'b00;
        eq_d     = 1'b0;
        mism_d   = {CW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    if (grant_s) begin
                        opa_d = bus.a1;
                        opb_d = bus.b1;
                    end else begin
                        opa_d = bus.a0;
                        opb_d = bus.b0;
                    end
                    gnt_d    = grant_s;
                    last_d   = grant_s;
                    eq_acc_d = 1'b1;
                    cnt_d    = {CW{1'b0}};
                    idx_d    = {IW{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                eq_acc_d = eq_next_s;
                cnt_d    = cnt_next_s;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IDX_LAST) begin
                    // Results are presented from registers during the DONE cycle.
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    eq_d    = eq_next_s;
                    mism_d  = cnt_next_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            idx_q    <= {IW{1'b0}};
            eq_acc_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 2'b00;
            eq_q     <= 1'b0;
            mism_q   <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            idx_q    <= idx_d;
            eq_acc_q <= eq_acc_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            eq_q     <= eq_d;
            mism_q   <= mism_d;
        end
    end

    // Cell inputs come straight from the operand registers and are forced low outside SHIFT.
    assign bus.xa     = (state_q == ST_SHIFT) ? opa_q[idx_q] : 1'b0;
    assign bus.xb     = (state_q == ST_SHIFT) ? opb_q[idx_q] : 1'b0;
    assign bus.ack    = ack_q;
    assign bus.eq     = eq_q;
    assign bus.mism   = mism_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_xnor_cmp_scheduler.sv
// Directed bench for xnor_cmp_scheduler: a behavioural XNOR cell, a stimulus thread
// that queues expected results, and a monitor that checks every ack pulse against the queue.
module tb_xnor_cmp_scheduler;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic [1:0]    ack;
        logic          eq;
        logic [CW-1:0] mism;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    xnor_cmp_scheduler_if #(.WIDTH(W)) bus ();
    assign bus.xc = ~(bus.xa ^ bus.xb);

    xnor_cmp_scheduler #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Count cycles from the current one until ack shows, bounded.
    task automatic wait_ack(input int start, output int n);
        n = start;
        while (bus.ack == 2'b00 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic push(input logic [1:0] a, input logic e, input logic [CW-1:0] m);
        exp_t x;
        x.ack = a;
        x.eq = e;
        x.mism = m;
        sb.push_back(x);
    endtask

    // Single-requester op, entered and left at #1 into an IDLE cycle.
    task automatic do_op(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic e, input logic [CW-1:0] m);
        int n;
        if (r == 2'b10) begin
            bus.a1 = a;
            bus.b1 = b;
        end else begin
            bus.a0 = a;
            bus.b0 = b;
        end
        bus.req = r;
        push(r, e, m);
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        chk("op_gnt_id", 64'(bus.gnt_id), 64'(r == 2'b10));
        wait_ack(1, n);
        chk("op_latency", 64'(n), 64'(W + 1));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.ack != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%0h required=none", bus.ack);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("mon_ack", 64'(bus.ack), 64'(x.ack));
                chk("mon_eq", 64'(bus.eq), 64'(x.eq));
                chk("mon_mism", 64'(bus.mism), 64'(x.mism));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] patt;

        // Test 1/2: reset with req0 held, then A5 vs A5 with the bit stream checked.
        bus.req = 2'b01;
        bus.a0 = 8'hA5;
        bus.b0 = 8'hA5;
        bus.a1 = 8'h00;
        bus.b1 = 8'h00;
        patt = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(bus.ack), 64'(0));
        chk("rst_eq", 64'(bus.eq), 64'(0));
        chk("rst_mism", 64'(bus.mism), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_gnt", 64'(bus.gnt_id), 64'(0));
        chk("rst_xa", 64'(bus.xa), 64'(0));
        chk("rst_xb", 64'(bus.xb), 64'(0));
        push(2'b01, 1'b1, CW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        chk("t1_busy", 64'(bus.busy), 64'(1));
        chk("t1_gnt", 64'(bus.gnt_id), 64'(0));
        for (int i = 0; i < W; i++) begin
            chk("t2_xa", 64'(bus.xa), 64'(patt[i]));
            chk("t2_xb", 64'(bus.xb), 64'(patt[i]));
            if (i < W - 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_ack(W, n);
        chk("t1_latency", 64'(n), 64'(W + 1));
        chk("t1_done_busy", 64'(bus.busy), 64'(1));
        chk("t1_done_xa", 64'(bus.xa), 64'(0));
        @(posedge clk);
        #1;
        chk("t1_idle_busy", 64'(bus.busy), 64'(0));
        chk("t1_idle_eq", 64'(bus.eq), 64'(0));

        // Test 3: requester 1 mismatches.
        do_op(2'b10, 8'hFF, 8'h0F, 1'b0, CW'(4));
        do_op(2'b10, 8'h00, 8'hFF, 1'b0, CW'(8));
        do_op(2'b01, 8'h81, 8'h80, 1'b0, CW'(1));

        // Test 5: operand change and req drop mid-SHIFT are ignored.
        bus.a0 = 8'h3C;
        bus.b0 = 8'h3C;
        bus.req = 2'b01;
        push(2'b01, 1'b1, CW'(0));
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.a0 = 8'h00;
        bus.req = 2'b00;
        wait_ack(4, n);
        chk("t5_latency", 64'(n), 64'(W + 1));
        @(posedge clk);
        #1;

        // Test 4: both requesters held from reset alternate with W+2 spacing.
        rst_n = 1'b0;
        bus.a0 = 8'hF0;
        bus.b0 = 8'hF0;
        bus.a1 = 8'h55;
        bus.b1 = 8'hAA;
        bus.req = 2'b11;
        push(2'b01, 1'b1, CW'(0));
        push(2'b10, 1'b0, CW'(8));
        push(2'b01, 1'b1, CW'(0));
        push(2'b10, 1'b0, CW'(8));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_first_gnt", 64'(bus.gnt_id), 64'(0));
        wait_ack(1, n);
        chk("t4_latency", 64'(n), 64'(W + 1));
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            wait_ack(1, n);
            chk("t4_spacing", 64'(n), 64'(W + 2));
            chk("t4_gnt", 64'(bus.gnt_id), 64'(k % 2));
        end
        bus.req = 2'b00;
        @(posedge clk);
        #1;

        // Test 6: reset at idx 4 drops the op; a fresh op then runs from bit 0.
        bus.a0 = 8'h0F;
        bus.b0 = 8'hF0;
        bus.req = 2'b01;
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(bus.busy), 64'(0));
        chk("t6_ack", 64'(bus.ack), 64'(0));
        chk("t6_xa", 64'(bus.xa), 64'(0));
        chk("t6_xb", 64'(bus.xb), 64'(0));
        push(2'b01, 1'b0, CW'(8));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        chk("t6_xa_bit0", 64'(bus.xa), 64'(1));
        chk("t6_xb_bit0", 64'(bus.xb), 64'(0));
        wait_ack(1, n);
        chk("t6_latency", 64'(n), 64'(W + 1));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
